reg_wr_arbiter: RTL and testbench
=================================

# reg_wr_arbiter

Write-port controller for the 8-bit register file: it arbitrates two writeback requesters (A: ALU result, B: load/move result) onto the file's single write port using valid/ready handshakes and fair round-robin. It also contains an optional clear sequencer that, on command, sweeps every register to a constant value. It sits between the execute/writeback stage and the register file's `wr_en`/`wr_addr`/`dat_in` inputs.

## Interface
- `pw`, default 2: register address width; the file holds 2**pw registers.
- `CLR_VAL`, default 8'h00: value written by the clear sweep.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  requester A has a write pending.
- `a_addr`  in  pw  requester A destination register.
- `a_data`  in  8  requester A write data.
- `a_ready`  out  1  A's request is accepted this cycle (combinational).
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same as A, for requester B.
- `clr_start`  in  1  one-cycle pulse that starts a clear sweep.
- `busy`  out  1  high while the sweep state is active.
- `wr_en`  out  1  registered; drives the register file write enable.
- `wr_addr`  out  pw  registered; drives the register file write address.
- `wr_dat`  out  8  registered; drives the register file `dat_in`.

## Operation
- FSM has two states:
  - ARB: normal arbitration; the reset state.
  - CLEAR: sweep in progress.
- A handshake completes when a requester's valid and ready are both high in the same cycle. At most one handshake completes per cycle.
- Ready generation in ARB:
  - If `clr_start` is low and only one requester is valid, that requester's ready is 1.
  - If both are valid, the requester that was not granted most recently gets ready. `last_grant` resets to B, so A wins the first tie.
  - `last_grant` updates only on a handshake.
- Ready is 0 for both requesters in CLEAR, and in any ARB cycle where `clr_start`=1 (clear has priority).
- Ready may depend on valid. Valid must not depend on ready.
- Once valid is raised, the requester holds valid, addr and data stable until the handshake completes.
- On a handshake, at the clock edge: `wr_en`<=1, `wr_addr`<=winner's addr, `wr_dat`<=winner's data.
- In an ARB cycle with no handshake: `wr_en`<=0. `wr_addr` and `wr_dat` hold their values.
- `clr_start`=1 in ARB: at the edge, state<=CLEAR and sweep counter `cnt`<=0.
- In CLEAR with `cnt`=c, at the edge: `wr_en`<=1, `wr_addr`<=c, `wr_dat`<=CLR_VAL, `cnt`<=c+1.
  - When c = 2**pw-1, state<=ARB and `cnt`<=0 (wrap).
- `clr_start` is ignored while in CLEAR.
- `busy` = (state==CLEAR), decoded from the state register.

## Timing
- Reset values:
  - state=ARB, `cnt`=0, `last_grant`=B.
  - `wr_en`=0, `wr_addr`=0, `wr_dat`=0, `busy`=0.
  - `a_ready`/`b_ready` then follow the ARB rules combinationally.
- Write latency: a handshake in cycle t gives `wr_en`=1 in cycle t+1; the register file captures the data at the end of t+1.
- Back-to-back handshakes in consecutive cycles give consecutive writes, with no bubble.
- Sweep: `clr_start` in cycle t gives:
  - `busy` high in cycles t+1 .. t+2**pw;
  - `wr_en` high in cycles t+2 .. t+1+2**pw, with addresses 0 .. 2**pw-1 in order.
- The first requester handshake after a sweep can occur in cycle t+1+2**pw. Its write then lands in t+2+2**pw, so there is no port conflict.
- Reset asserted mid-sweep: all state returns to reset values immediately. The sweep is abandoned and registers already cleared stay cleared.
- There is no same-cycle read bypass. A read in the cycle where `wr_en` is high sees the old value.

## Configuration
- Macro `REG_WR_ARB_SWEEP_EN`.
- Defined: the clear sequencer is built exactly as described above.
- Undefined:
  - No CLEAR state and no `cnt` register.
  - `clr_start` is accepted but ignored.
  - `busy` is tied to 0.
  - Ready generation never blocks for clear.
- The port list is identical in both builds.

## Structure
- Package `reg_arb_pkg` holds:
  - typedef `arb_state_t` enum {ARB, CLEAR};
  - typedef `req_id_t` enum {REQ_A, REQ_B};
  - localparam `DW`=8 (data width).
- Sub-module `rr_pick2` is a combinational 2-way round-robin picker:
  - inputs: two valids, `last_grant`, a block input;
  - outputs: two one-hot readies.
- The `last_grant` flop and the write-port flops stay in `reg_wr_arbiter`.

## Test plan
- Reset, then idle → `wr_en`=0, `busy`=0; `a_ready`=1 as soon as `a_valid`=1.
- A only: addr 1, data 8'h5A, one cycle → next cycle `wr_en`=1, `wr_addr`=1, `wr_dat`=8'h5A; the following cycle `wr_en`=0.
- A and B both valid and held for 4 cycles (A: addr 0, 8'h11; B: addr 3, 8'h22) → grants A, B, A, B; writes appear one cycle later in the same order.
- `clr_start` pulse with `pw`=2 and B valid → `b_ready`=0 for 5 cycles; writes of 8'h00 to addrs 0,1,2,3; then B is granted and its write follows immediately.
- `reset` asserted at the 2nd sweep write → all outputs 0 at once, state ARB; after release, A is granted first on a tie.
- Build without `REG_WR_ARB_SWEEP_EN`, pulse `clr_start` → no writes, `busy` stays 0, arbitration is unaffected.

Source files
------------

// File: rtl/reg_wr_arbiter_pkg.sv
// reg_arb_pkg: shared types and widths for the register-file write-port arbiter.
package reg_arb_pkg;
    localparam int DW = 8;
    typedef enum logic {ARB, CLEAR} arb_state_t;
    typedef enum logic {REQ_A, REQ_B} req_id_t;
endpackage

// File: rtl/reg_wr_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker; readies are at most one-hot.
module rr_pick2
    import reg_arb_pkg::*;
(
    input  logic    a_valid,
    input  logic    b_valid,
    input  req_id_t last_grant,
    input  logic    blk,
    output logic    a_ready,
    output logic    b_ready
);
    always_comb begin
        a_ready = !blk && a_valid && (!b_valid || last_grant == REQ_B);
        b_ready = !blk && b_valid && (!a_valid || last_grant == REQ_A);
    end
endmodule

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: arbitrates two writeback requesters onto the register file write port.
// The clear sweep sequencer is built only when REG_WR_ARB_SWEEP_EN is defined.
module reg_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int            pw      = 2,
    parameter logic [DW-1:0] CLR_VAL = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [pw-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [pw-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          clr_start,
    output logic          busy,
    output logic          wr_en,
    output logic [pw-1:0] wr_addr,
    output logic [DW-1:0] wr_dat
);
    req_id_t       last_grant_q, last_grant_d;
    logic          wr_en_q, wr_en_d;
    logic [pw-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_dat_q, wr_dat_d;
    logic          blk, a_hs, b_hs, sweep_wr;
    logic [pw-1:0] sweep_addr;

    rr_pick2 u_pick (
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .last_grant (last_grant_q),
        .blk        (blk),
        .a_ready    (a_ready),
        .b_ready    (b_ready)
    );

`ifdef REG_WR_ARB_SWEEP_EN
    arb_state_t    state_q, state_d;
    logic [pw-1:0] cnt_q, cnt_d;

    assign blk        = (state_q == CLEAR) || clr_start;
    assign busy       = state_q == CLEAR;
    assign sweep_wr   = state_q == CLEAR;
    assign sweep_addr = cnt_q;

    // cnt wraps to zero on the last address, leaving it ready for the next sweep
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d   = cnt_q + pw'(1);
            state_d = (&cnt_q) ? ARB : CLEAR;
        end else if (clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_clr;

    assign unused_clr = clr_start;
    assign blk        = 1'b0;
    assign busy       = 1'b0;
    assign sweep_wr   = 1'b0;
    assign sweep_addr = '0;
`endif

    assign a_hs = a_valid && a_ready;
    assign b_hs = b_valid && b_ready;

    // readies are blocked during a sweep, so the sweep never collides with a handshake
    always_comb begin
        wr_en_d      = sweep_wr || a_hs || b_hs;
        wr_addr_d    = sweep_wr ? sweep_addr : a_hs ? a_addr : b_hs ? b_addr : wr_addr_q;
        wr_dat_d     = sweep_wr ? CLR_VAL : a_hs ? a_data : b_hs ? b_data : wr_dat_q;
        last_grant_d = a_hs ? REQ_A : b_hs ? REQ_B : last_grant_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= REQ_B;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_dat_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_dat_q     <= wr_dat_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_dat  = wr_dat_q;
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb_reg_wr_arbiter: directed scoreboard bench for reg_wr_arbiter (pw=2).
// Sweep checks are compiled in when REG_WR_ARB_SWEEP_EN is defined.
module tb_reg_wr_arbiter;
    localparam logic [7:0] CV = 8'hA5;

    logic       clk, reset;
    logic       a_valid, b_valid, clr_start;
    logic [1:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, busy, wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_dat;

    int errs = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    reg_wr_arbiter #(.pw(2), .CLR_VAL(CV)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .clr_start(clr_start), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [1:0] aa, input logic [7:0] ad,
                         input logic bv, input logic [1:0] ba, input logic [7:0] bd,
                         input logic clr);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        clr_start = clr;
    endtask

    // checks this cycle's readies/busy, predicts the write, then checks the write port after the edge
    task automatic step(input logic ear, input logic ebr, input logic ebusy);
        logic [9:0] e;
        #1;
        chk("a_ready", a_ready, ear);
        chk("b_ready", b_ready, ebr);
        chk("busy", busy, ebusy);
        if (ear) exp_q.push_back({a_addr, a_data});
        if (ebr) exp_q.push_back({b_addr, b_data});
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_en", wr_en, 1);
            chk("wr_addr", wr_addr, e[9:8]);
            chk("wr_dat", wr_dat, e[7:0]);
        end else begin
            chk("wr_en_idle", wr_en, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_dat", wr_dat, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(0, 0, 0);
        // tie from reset: A first, then alternate
        drive(1, 2'd0, 8'h11, 1, 2'd3, 8'h22, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        drive(1, 2'd1, 8'h5A, 0, 0, 0, 0);
        step(1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0);
`ifdef REG_WR_ARB_SWEEP_EN
        drive(0, 0, 0, 1, 2'd2, 8'h33, 1);
        step(0, 0, 0);
        clr_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back({2'(c), CV});
            step(0, 0, 1);
        end
        step(0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0);
`else
        drive(0, 0, 0, 1, 2'd2, 8'h33, 1);
        step(0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0);
        clr_start = 1'b0;
        step(0, 0, 0);
`endif
        drive(1, 2'd3, 8'h77, 0, 0, 0, 0);
        step(1, 0, 0);
`ifdef REG_WR_ARB_SWEEP_EN
        drive(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0);
        clr_start = 1'b0;
        exp_q.push_back({2'd0, CV});
        step(0, 0, 1);
        exp_q.push_back({2'd1, CV});
        step(0, 0, 1);
`endif
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_dat", wr_dat, 0);
        chk("mid_rst_busy", busy, 0);
        drive(1, 2'd0, 8'h11, 1, 2'd3, 8'h22, 0);
        #1;
        chk("mid_rst_a_ready", a_ready, 1);
        chk("mid_rst_b_ready", b_ready, 0);
        reset = 1'b0;
        step(1, 0, 0);
        step(0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
